rsa_modexp_ctrl: RTL and testbench

//  Sequences one external Montgomery multiplier to compute o_crypto = msg^key mod N.

---
 rtl/rsa_modexp_ctrl.sv | 130 +++++++++++++
 tb/tb_rsa_modexp_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_ctrl.sv
// Right-to-left binary modular exponentiation sequencer driving one external Montgomery multiplier.
// The message arrives in Montgomery form. The result register starts at a normal-domain 1, so the result leaves in the normal domain.
module rsa_modexp_ctrl #(
    parameter int MOD_WIDTH = 256,
    parameter int E_WIDTH   = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [MOD_WIDTH-1:0] i_msg,
    input  logic [E_WIDTH-1:0]   i_key,
    input  logic [MOD_WIDTH-1:0] i_modulus,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [MOD_WIDTH-1:0] o_crypto,
    output logic                 mont_i_valid,
    input  logic                 mont_i_ready,
    output logic [MOD_WIDTH-1:0] mont_a,
    output logic [MOD_WIDTH-1:0] mont_b,
    output logic [MOD_WIDTH-1:0] mont_modulus,
    input  logic                 mont_o_valid,
    output logic                 mont_o_ready,
    input  logic [MOD_WIDTH-1:0] mont_out,
    output logic [2:0]           dbg_state
);

    localparam int CNT_W = $clog2(E_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(E_WIDTH - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] MUL_REQ  = 3'd1;
    localparam logic [2:0] MUL_WAIT = 3'd2;
    localparam logic [2:0] SQR_REQ  = 3'd3;
    localparam logic [2:0] SQR_WAIT = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;

    logic [2:0]           state;
    logic [MOD_WIDTH-1:0] res;
    logic [MOD_WIDTH-1:0] sqr;
    logic [E_WIDTH-1:0]   exp_sr;
    logic [MOD_WIDTH-1:0] n_q;
    logic [CNT_W-1:0]     cnt;

    // Every channel transfers on the cycle where valid && ready are both high.
    // A raised valid is held, with its payload unchanged, until that cycle.
    // Requests are only raised in *_REQ states and results are only accepted in *_WAIT states.
    // So at most one multiplier operation is outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            res    <= '0;
            sqr    <= '0;
            exp_sr <= '0;
            n_q    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        res    <= MOD_WIDTH'(1);
                        sqr    <= i_msg;
                        exp_sr <= i_key;
                        n_q    <= i_modulus;
                        cnt    <= '0;
                        state  <= MUL_REQ;
                    end
                end
                MUL_REQ: begin
                    if (!exp_sr[0]) begin
                        state <= SQR_REQ;
                    end else if (mont_i_ready) begin
                        state <= MUL_WAIT;
                    end
                end
                MUL_WAIT: begin
                    if (mont_o_valid) begin
                        res   <= mont_out;
                        state <= (cnt == LAST_BIT) ? DONE : SQR_REQ;
                    end
                end
                SQR_REQ: begin
                    // The square after the top exponent bit would never be used.
                    if (cnt == LAST_BIT) begin
                        state <= DONE;
                    end else if (mont_i_ready) begin
                        state <= SQR_WAIT;
                    end
                end
                SQR_WAIT: begin
                    if (mont_o_valid) begin
                        sqr    <= mont_out;
                        exp_sr <= exp_sr >> 1;
                        cnt    <= cnt + CNT_W'(1);
                        state  <= MUL_REQ;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        i_ready      = (state == IDLE);
        mont_o_ready = (state == MUL_WAIT) || (state == SQR_WAIT);
        mont_i_valid = 1'b0;
        mont_a       = '0;
        mont_b       = '0;
        if ((state == MUL_REQ) && exp_sr[0]) begin
            mont_i_valid = 1'b1;
            mont_a       = res;
            mont_b       = sqr;
        end else if ((state == SQR_REQ) && (cnt != LAST_BIT)) begin
            mont_i_valid = 1'b1;
            mont_a       = sqr;
            mont_b       = sqr;
        end
        o_valid  = (state == DONE);
        o_crypto = (state == DONE) ? res : '0;
    end

    assign mont_modulus = n_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Directed bench for rsa_modexp_ctrl with N=13 and an 8-bit width. It includes a behavioural Montgomery multiplier with optional stalls.
module tb_rsa_modexp_ctrl;

    localparam int MW    = 8;
    localparam int EW    = 8;
    localparam int N_MOD = 13;
    localparam int R_INV = 3;  // 256^-1 mod 13

    logic          clk;
    logic          rst;
    logic          i_valid;
    logic          i_ready;
    logic [MW-1:0] i_msg;
    logic [EW-1:0] i_key;
    logic [MW-1:0] i_modulus;
    logic          o_valid;
    logic          o_ready;
    logic [MW-1:0] o_crypto;
    logic          mont_i_valid;
    logic          mont_i_ready;
    logic [MW-1:0] mont_a;
    logic [MW-1:0] mont_b;
    logic [MW-1:0] mont_modulus;
    logic          mont_o_valid;
    logic          mont_o_ready;
    logic [MW-1:0] mont_out;
    logic [2:0]    dbg_state;

    int            n_checks;
    int            n_fail;
    int            op_count;
    bit            stall_en;
    bit            busy;
    bit            res_taken;
    bit            hold_pend;
    int            lat;
    logic [MW-1:0] pend;
    logic [MW-1:0] hold_a;
    logic [MW-1:0] hold_b;
    logic [MW-1:0] cur_mod;
    logic [MW-1:0] exp_q[$];

    rsa_modexp_ctrl #(.MOD_WIDTH(MW), .E_WIDTH(EW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .i_ready      (i_ready),
        .i_msg        (i_msg),
        .i_key        (i_key),
        .i_modulus    (i_modulus),
        .o_valid      (o_valid),
        .o_ready      (o_ready),
        .o_crypto     (o_crypto),
        .mont_i_valid (mont_i_valid),
        .mont_i_ready (mont_i_ready),
        .mont_a       (mont_a),
        .mont_b       (mont_b),
        .mont_modulus (mont_modulus),
        .mont_o_valid (mont_o_valid),
        .mont_o_ready (mont_o_ready),
        .mont_out     (mont_out),
        .dbg_state    (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    function automatic logic [MW-1:0] mont_model(input logic [MW-1:0] a, input logic [MW-1:0] b);
        int p;
        p = (int'(a) * int'(b)) % N_MOD;
        p = (p * R_INV) % N_MOD;
        return MW'(p);
    endfunction

    // Multiplier model: inputs change at negedge, handshakes are observed 1 time unit before posedge.
    initial begin
        mont_i_ready = 1'b0;
        mont_o_valid = 1'b0;
        mont_out     = '0;
        busy         = 1'b0;
        res_taken    = 1'b0;
        hold_pend    = 1'b0;
        lat          = 0;
        forever begin
            @(negedge clk);
            if (res_taken) begin
                mont_o_valid = 1'b0;
                busy         = 1'b0;
                res_taken    = 1'b0;
            end
            if (busy && !mont_o_valid) begin
                if (lat == 0) begin
                    mont_o_valid = 1'b1;
                    mont_out     = pend;
                end else begin
                    lat--;
                end
            end
            mont_i_ready = !busy && (!stall_en || ($urandom_range(0, 2) == 0));
            #4;
            if (!rst) begin
                busy         = 1'b0;
                res_taken    = 1'b0;
                hold_pend    = 1'b0;
                mont_o_valid = 1'b0;
            end else begin
                if (mont_i_valid) begin
                    check_eq("no_overlap", 32'(mont_o_ready), 32'(0));
                    check_eq("mont_modulus", 32'(mont_modulus), 32'(cur_mod));
                    if (hold_pend) begin
                        check_eq("stall_a", 32'(mont_a), 32'(hold_a));
                        check_eq("stall_b", 32'(mont_b), 32'(hold_b));
                    end
                    if (mont_i_ready) begin
                        pend      = mont_model(mont_a, mont_b);
                        busy      = 1'b1;
                        lat       = stall_en ? int'($urandom_range(0, 4)) : 0;
                        hold_pend = 1'b0;
                        op_count++;
                    end else begin
                        hold_pend = 1'b1;
                        hold_a    = mont_a;
                        hold_b    = mont_b;
                    end
                end else if (hold_pend) begin
                    check_eq("stall_valid_held", 32'(mont_i_valid), 32'(1));
                    hold_pend = 1'b0;
                end
                if (mont_o_valid && mont_o_ready) res_taken = 1'b1;
            end
        end
    end

    task automatic start_job(input logic [MW-1:0] msg, input logic [EW-1:0] key);
        @(negedge clk);
        i_msg     = msg;
        i_key     = key;
        i_modulus = MW'(N_MOD);
        cur_mod   = MW'(N_MOD);
        op_count  = 0;
        i_valid   = 1'b1;
        @(negedge clk);
        i_valid   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic [MW-1:0] want;
        int i;
        want = exp_q.pop_front();
        i = 0;
        while (!o_valid && i < 1000) begin
            @(negedge clk);
            i++;
        end
        if (!o_valid) check_eq({tag, "_timeout"}, 32'(0), 32'(1));
        else check_eq({tag, "_crypto"}, 32'(o_crypto), 32'(want));
    endtask

    task automatic release_job(input string tag, input int ops);
        check_eq({tag, "_ops"}, 32'(op_count), 32'(ops));
        o_ready = 1'b1;
        @(negedge clk);
        o_ready = 1'b0;
        check_eq({tag, "_ovalid_drop"}, 32'(o_valid), 32'(0));
        check_eq({tag, "_iready_back"}, 32'(i_ready), 32'(1));
    endtask

    task automatic run_job(input string tag, input logic [MW-1:0] msg, input logic [EW-1:0] key,
                           input logic [MW-1:0] want, input int ops);
        exp_q.push_back(want);
        start_job(msg, key);
        wait_done(tag);
        release_job(tag, ops);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        op_count  = 0;
        stall_en  = 1'b0;
        cur_mod   = '0;
        rst       = 1'b0;
        i_valid   = 1'b0;
        i_msg     = '0;
        i_key     = '0;
        i_modulus = '0;
        o_ready   = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("rst_i_ready", 32'(i_ready), 32'(1));
        check_eq("rst_o_valid", 32'(o_valid), 32'(0));
        check_eq("rst_o_crypto", 32'(o_crypto), 32'(0));
        check_eq("rst_mont_i_valid", 32'(mont_i_valid), 32'(0));
        check_eq("rst_mont_o_ready", 32'(mont_o_ready), 32'(0));
        check_eq("rst_mont_a", 32'(mont_a), 32'(0));
        check_eq("rst_mont_b", 32'(mont_b), 32'(0));
        check_eq("rst_mont_modulus", 32'(mont_modulus), 32'(0));
        rst = 1'b1;

        // msg=2 -> Montgomery form 2*256 mod 13 = 5; msg=3 -> 27 mod 13 = 1
        run_job("key05", 8'd5, 8'h05, 8'd6, 9);
        run_job("key00", 8'd5, 8'h00, 8'd1, 7);
        run_job("keyFF", 8'd5, 8'hFF, 8'd8, 15);
        run_job("key80", 8'd5, 8'h80, 8'd9, 8);
        run_job("msg3_key05", 8'd1, 8'h05, 8'd9, 9);

        stall_en = 1'b1;
        run_job("stall_key05", 8'd5, 8'h05, 8'd6, 9);
        run_job("stall_keyFF", 8'd5, 8'hFF, 8'd8, 15);
        run_job("stall_keyA3", 8'd5, 8'hA3, 8'd11, 11);
        stall_en = 1'b0;

        // Hold the result for 10 cycles while a second request is offered.
        exp_q.push_back(8'd6);
        start_job(8'd5, 8'h05);
        wait_done("hold");
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                i_msg   = 8'd7;
                i_key   = 8'h3C;
                i_valid = 1'b1;
            end
            if (i == 4) i_valid = 1'b0;
            @(negedge clk);
            check_eq("hold_o_valid", 32'(o_valid), 32'(1));
            check_eq("hold_o_crypto", 32'(o_crypto), 32'(6));
            check_eq("hold_i_ready", 32'(i_ready), 32'(0));
        end
        release_job("hold", 9);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("hold_no_second_job", 32'(i_ready), 32'(1));
        end

        // Asynchronous reset while a square is outstanding.
        start_job(8'd5, 8'h05);
        begin
            int i;
            i = 0;
            while (dbg_state != 3'd4 && i < 200) begin
                @(negedge clk);
                i++;
            end
            check_eq("reach_sqr_wait", 32'(dbg_state), 32'(4));
        end
        rst = 1'b0;
        #1;
        check_eq("midrst_i_ready", 32'(i_ready), 32'(1));
        check_eq("midrst_o_valid", 32'(o_valid), 32'(0));
        check_eq("midrst_mont_i_valid", 32'(mont_i_valid), 32'(0));
        check_eq("midrst_mont_o_ready", 32'(mont_o_ready), 32'(0));
        check_eq("midrst_mont_modulus", 32'(mont_modulus), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        check_eq("postrst_i_ready", 32'(i_ready), 32'(1));
        run_job("after_rst_keyFF", 8'd5, 8'hFF, 8'd8, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
